// File: rtl/fa_serial_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : inf
//  Description : Single-bit full-adder interface. The stimulus side uses the
//                drv modport to own a, b and cin and to sample sum and
//                carry. The adder side uses the fa modport.
//  Signals     : a, b, cin  - operand bits and carry-in (driven by drv)
//                sum, carry - full-adder outputs (driven by fa)
//  Revision    : 1.0 - initial release
// ============================================================================
interface inf;
  logic a;
  logic b;
  logic cin;
  logic sum;
  logic carry;

  modport drv (output a, b, cin, input sum, carry);
  modport fa  (input a, b, cin, output sum, carry);
endinterface
`default_nettype wire

// File: rtl/fa_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module      : fa_serial_driver
//  Description : Bit-serial adder front end. Accepts two W-bit operands plus
//                a carry-in, streams them LSB first through an external
//                single-bit full adder (one bit per clock), feeds each carry
//                back as the next cin, and returns a W-bit sum plus carry-out.
//  Ports       : clk        - clock, all state changes on posedge
//                rst_n      - synchronous active-low reset
//                in_valid   - operands presented
//                in_ready   - operands can be accepted (IDLE only)
//                op_a, op_b - W-bit operands
//                cin_in     - carry-in for bit 0
//                out_valid  - result/cout valid, held until accepted
//                out_ready  - consumer accepts result
//                result     - W-bit sum
//                cout       - final carry-out
//                f          - inf.drv: drives a/b/cin, samples sum/carry
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_serial_driver #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  inf.drv              f
);

  // A one-bit counter is kept even for W=1 so the index is never zero-width.
  localparam int               CNT_W    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [W-1:0]     result_q;
  logic             cout_q;
  logic             out_valid_q;
  logic             in_ready_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  // The adder only sees live operand bits while shifting; it is quiet
  // otherwise so the shared interface never carries stale data.
  assign f.a   = (state_q == SHIFT) ? a_q[cnt_q] : 1'b0;
  assign f.b   = (state_q == SHIFT) ? b_q[cnt_q] : 1'b0;
  assign f.cin = (state_q == SHIFT) ? carry_q    : 1'b0;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= op_a;
            b_q        <= op_b;
            carry_q    <= cin_in;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          result_q[cnt_q] <= f.sum;
          carry_q         <= f.carry;
          if (cnt_q == CNT_LAST) begin
            // Counter is left at its last value rather than wrapping.
            cout_q      <= f.carry;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DONE: begin
          // Returning to IDLE takes a full cycle; in_ready rises only there,
          // so a new operation can never be accepted on the handshake edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fa_serial_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fa_serial_driver
//  Description : Self-checking bench for fa_serial_driver at W=8, W=1 and
//                W=16. The bench plays the full adder on each interface.
//                Expected results enter a scoreboard when operands are
//                accepted and are compared when the result is handed off.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fa_serial_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        out_ready;
  int          cur_w;

  always #5 clk = ~clk;

  // Per-width DUT signals
  logic        ir1, ov1, co1, res1;
  logic        ir8, ov8, co8;
  logic [7:0]  res8;
  logic        ir16, ov16, co16;
  logic [15:0] res16;

  inf f1();
  inf f8();
  inf f16();

  // Full adders behind each interface
  assign f1.sum   = f1.a ^ f1.b ^ f1.cin;
  assign f1.carry = (f1.a & f1.b) | (f1.a & f1.cin) | (f1.b & f1.cin);
  assign f8.sum   = f8.a ^ f8.b ^ f8.cin;
  assign f8.carry = (f8.a & f8.b) | (f8.a & f8.cin) | (f8.b & f8.cin);
  assign f16.sum   = f16.a ^ f16.b ^ f16.cin;
  assign f16.carry = (f16.a & f16.b) | (f16.a & f16.cin) | (f16.b & f16.cin);

  fa_serial_driver #(.W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (cur_w == 1)), .in_ready(ir1),
    .op_a(op_a[0]), .op_b(op_b[0]), .cin_in(cin), .out_valid(ov1),
    .out_ready(out_ready), .result(res1), .cout(co1), .f(f1)
  );

  fa_serial_driver #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (cur_w == 8)), .in_ready(ir8),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]), .cin_in(cin), .out_valid(ov8),
    .out_ready(out_ready), .result(res8), .cout(co8), .f(f8)
  );

  fa_serial_driver #(.W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (cur_w == 16)), .in_ready(ir16),
    .op_a(op_a), .op_b(op_b), .cin_in(cin), .out_valid(ov16),
    .out_ready(out_ready), .result(res16), .cout(co16), .f(f16)
  );

  // View of the DUT currently under test
  logic        m_valid, m_ready, m_cout, m_cin, m_a, m_b;
  logic [15:0] m_res;

  always_comb begin
    m_valid = ov8;
    m_ready = ir8;
    m_res   = {8'h00, res8};
    m_cout  = co8;
    m_cin   = f8.cin;
    m_a     = f8.a;
    m_b     = f8.b;
    if (cur_w == 1) begin
      m_valid = ov1;
      m_ready = ir1;
      m_res   = {15'h0000, res1};
      m_cout  = co1;
      m_cin   = f1.cin;
      m_a     = f1.a;
      m_b     = f1.b;
    end else if (cur_w == 16) begin
      m_valid = ov16;
      m_ready = ir16;
      m_res   = res16;
      m_cout  = co16;
      m_cin   = f16.cin;
      m_a     = f16.a;
      m_b     = f16.b;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] res;
    logic        co;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (W=%0d) t=%0t: got %0h expected %0h", name, cur_w, $time, act, exp);
    end
  endtask

  task automatic sb_compare();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard empty (W=%0d) t=%0t: got result %0h", cur_w, $time, m_res);
    end else begin
      e = sb.pop_front();
      check("result", m_res, e.res);
      check("cout", m_cout, e.co);
    end
  endtask

  // Runs one operation end to end. Called just after a negedge with the
  // selected DUT in IDLE; returns just after a negedge with it back in IDLE.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] exp_res, input logic exp_co, input bit rnd);
    logic [16:0] s17;
    logic [15:0] mask;
    logic [15:0] exp_tr;
    logic [15:0] cin_tr;
    exp_t        e;
    int          k;
    int          g;
    mask   = 16'((17'h1 << cur_w) - 17'h1);
    s17    = {1'b0, a & mask} + {1'b0, b & mask} + {16'h0000, c};
    // Carry into bit i is sum bit i xor the two operand bits.
    exp_tr = (s17[15:0] ^ a ^ b) & mask;
    check("in_ready idle", m_ready, 1);
    op_a     = a;
    op_b     = b;
    cin      = c;
    in_valid = 1'b1;
    e.res    = exp_res;
    e.co     = exp_co;
    sb.push_back(e);
    @(negedge clk);
    // Junk operands while busy must not be picked up.
    in_valid = 1'b0;
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
    cin      = 1'($urandom_range(0, 1));
    check("in_ready busy", m_ready, 0);
    cin_tr = '0;
    k      = 0;
    while (!m_valid && k < cur_w + 4) begin
      if (k < 16) cin_tr[k] = m_cin;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      k++;
    end
    check("out_valid rises", m_valid, 1);
    check("latency", k, cur_w);
    check("f.cin trace", cin_tr, exp_tr);
    g         = 0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!out_ready) begin
      @(negedge clk);
      g++;
      check("out_valid held", m_valid, 1);
      check("result held", m_res, exp_res);
      out_ready = (g >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    sb_compare();
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid drop", m_valid, 0);
    check("in_ready back", m_ready, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] res;
    logic       co;
  } vec_t;

  vec_t vec[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] s17;
    logic [15:0] a, b, mask;
    logic        c;
    bit          seen;

    vec[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vec[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vec[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vec[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vec[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vec[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vec[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vec[7] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

    cur_w     = 8;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset in_ready", m_ready, 1);
    check("reset out_valid", m_valid, 0);
    check("reset result", m_res, 0);
    check("reset cout", m_cout, 0);
    check("reset f.a/b/cin", {m_a, m_b, m_cin}, 0);

    // Directed vectors at W=8
    for (int i = 0; i < 8; i++) begin
      run_op(16'(vec[i].a), 16'(vec[i].b), vec[i].c, 16'(vec[i].res), vec[i].co, 1'b0);
    end

    // Backpressure in DONE with new operands offered
    op_a     = 16'h0012;
    op_b     = 16'h0034;
    cin      = 1'b0;
    in_valid = 1'b1;
    sb.push_back('{res: 16'h0046, co: 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 12 && !m_valid; k++) @(negedge clk);
    check("bp out_valid", m_valid, 1);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op_a      = 16'h00AA;
      op_b      = 16'h00BB;
      cin       = 1'b1;
      @(negedge clk);
      check("bp held out_valid", m_valid, 1);
      check("bp in_ready low", m_ready, 0);
      check("bp result stable", m_res, 16'h0046);
      check("bp cout stable", m_cout, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sb_compare();
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release out_valid", m_valid, 0);
    check("bp release in_ready", m_ready, 1);
    @(negedge clk);
    check("bp stays idle", m_ready, 1);

    // Reset while shifting with cnt=3
    op_a     = 16'h0077;
    op_b     = 16'h0011;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort in_ready", m_ready, 1);
    check("abort out_valid", m_valid, 0);
    check("abort result", m_res, 0);
    check("abort cout", m_cout, 0);
    check("abort f.a/b/cin", {m_a, m_b, m_cin}, 0);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check("abort no out_valid", seen, 0);
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

    // Random operations at W=1 and W=16 with random out_ready
    for (int wi = 0; wi < 2; wi++) begin
      cur_w = (wi == 0) ? 1 : 16;
      mask  = 16'((17'h1 << cur_w) - 17'h1);
      @(negedge clk);
      for (int n = 0; n < 200; n++) begin
        if (n == 0) begin
          a = mask;
          b = mask;
          c = 1'b1;
        end else begin
          a = 16'($urandom) & mask;
          b = 16'($urandom) & mask;
          c = 1'($urandom_range(0, 1));
        end
        s17 = {1'b0, a} + {1'b0, b} + {16'h0000, c};
        run_op(a, b, c, s17[15:0] & mask, s17[cur_w], 1'b1);
      end
    end

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
